// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared widths and transaction type for the dispatch block
// Purpose: id/qos/payload widths, id space size and the packed transaction
//          record carried through the staging FIFO.
// Ports:   none (package)
package enigma_pkg;

  localparam int ENIGMA_ID_W      = 6;
  localparam int ENIGMA_QOS_W     = 2;
  localparam int ENIGMA_PAYLOAD_W = 128;
  localparam int ENIGMA_ID_NUM    = 64;

  typedef struct packed {
    logic [ENIGMA_PAYLOAD_W-1:0] payload;
    logic [ENIGMA_ID_W-1:0]      id;
    logic [ENIGMA_QOS_W-1:0]     qos;
  } enigma_txn_t;

  localparam int ENIGMA_TXN_W = $bits(enigma_txn_t);

endpackage

// File: rtl/enigma_sync_fifo.sv
// rtl/enigma_sync_fifo.sv - single-clock FIFO with zero-latency head read
// Purpose: output staging queue; pop_data is the head entry combinationally.
// Ports:   clk, rst_n (async active-low)
//          push, push_data      - write side (ignored when full)
//          pop, pop_data        - read side (ignored when empty)
//          full, empty          - status
module enigma_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells full from empty when the indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/enigma_dispatch.sv
// rtl/enigma_dispatch.sv - id-tracking dispatcher with output staging FIFO
// Purpose: accepts transactions whose id is not in flight, stages them in a
//          FIFO toward downstream, and retires ids on downstream completion.
// Ports:   clk, rst_n (async active-low)
//          valid_c/ready_c/payload_c/id_c/qos_c - upstream offer
//          conflict_c                           - offered id already in flight
//          release_c/releaseid_c                - one-cycle retire pulse
//          out_valid/out_ready/out_payload/out_id/out_qos - downstream issue
//          done_valid/done_id                   - downstream completion
//          outstanding                          - in-flight id count
//          err_spurious                         - sticky stray completion flag
module enigma_dispatch
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_c,
  output logic                        ready_c,
  input  logic [ENIGMA_PAYLOAD_W-1:0] payload_c,
  input  logic [ENIGMA_ID_W-1:0]      id_c,
  input  logic [ENIGMA_QOS_W-1:0]     qos_c,
  output logic                        conflict_c,
  output logic                        release_c,
  output logic [ENIGMA_ID_W-1:0]      releaseid_c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ENIGMA_PAYLOAD_W-1:0] out_payload,
  output logic [ENIGMA_ID_W-1:0]      out_id,
  output logic [ENIGMA_QOS_W-1:0]     out_qos,
  input  logic                        done_valid,
  input  logic [ENIGMA_ID_W-1:0]      done_id,
  output logic [6:0]                  outstanding,
  output logic                        err_spurious
);

  logic [ENIGMA_ID_NUM-1:0] busy;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        done_hit;
  logic        done_miss;
  enigma_txn_t push_txn;
  enigma_txn_t head_txn;

  assign conflict_c = valid_c && busy[id_c];
  assign ready_c    = !fifo_full;
  assign accept     = valid_c && ready_c && !conflict_c;
  assign done_hit   = done_valid && busy[done_id];
  assign done_miss  = done_valid && !busy[done_id];

  assign push_txn = '{payload: payload_c, id: id_c, qos: qos_c};

  enigma_sync_fifo #(
    .WIDTH (ENIGMA_TXN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_txn),
    .pop       (out_ready),
    .pop_data  (head_txn),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign out_payload = head_txn.payload;
  assign out_id      = head_txn.id;
  assign out_qos     = head_txn.qos;

  // accept and done_hit never target the same id (conflict_c blocks it), so
  // clearing and setting in one edge cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= '0;
      outstanding  <= '0;
      release_c    <= 1'b0;
      releaseid_c  <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (done_hit) busy[done_id] <= 1'b0;
      if (accept)   busy[id_c]    <= 1'b1;
      case ({accept, done_hit})
        2'b10:   outstanding <= outstanding + 7'd1;
        2'b01:   outstanding <= outstanding - 7'd1;
        default: outstanding <= outstanding;
      endcase
      release_c    <= done_hit;
      releaseid_c  <= done_hit ? done_id : '0;
      err_spurious <= err_spurious || done_miss;
    end
  end

endmodule

// File: tb/tb_enigma_dispatch.sv
// tb/tb_enigma_dispatch.sv - directed self-checking bench for enigma_dispatch
// Purpose: directed scenarios for accept, conflict, release, FIFO fill/drain,
//          concurrent accept/complete, spurious completion and reset.
// Ports:   none (bench top)
module tb_enigma_dispatch;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_c;
  logic         ready_c;
  logic [127:0] payload_c;
  logic [5:0]   id_c;
  logic [1:0]   qos_c;
  logic         conflict_c;
  logic         release_c;
  logic [5:0]   releaseid_c;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_payload;
  logic [5:0]   out_id;
  logic [1:0]   out_qos;
  logic         done_valid;
  logic [5:0]   done_id;
  logic [6:0]   outstanding;
  logic         err_spurious;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  enigma_dispatch #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_c      (valid_c),
    .ready_c      (ready_c),
    .payload_c    (payload_c),
    .id_c         (id_c),
    .qos_c        (qos_c),
    .conflict_c   (conflict_c),
    .release_c    (release_c),
    .releaseid_c  (releaseid_c),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_payload  (out_payload),
    .out_id       (out_id),
    .out_qos      (out_qos),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .outstanding  (outstanding),
    .err_spurious (err_spurious)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] id, input logic [1:0] qos, input logic [127:0] pl);
    valid_c   = 1'b1;
    id_c      = id;
    qos_c     = qos;
    payload_c = pl;
  endtask

  initial begin
    rst_n      = 1'b0;
    valid_c    = 1'b0;
    payload_c  = '0;
    id_c       = '0;
    qos_c      = '0;
    out_ready  = 1'b0;
    done_valid = 1'b0;
    done_id    = '0;
    tick();
    tick();
    chk("rst_out_valid",   out_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_conflict",    conflict_c, 0);
    chk("rst_release",     release_c, 0);
    chk("rst_err",         err_spurious, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", ready_c, 1);

    // Accept id 5, visible on out_* the next cycle.
    out_ready = 1'b1;
    offer(6'd5, 2'd2, {16{8'hA5}});
    #1;
    chk("a5_conflict", conflict_c, 0);
    tick();
    valid_c = 1'b0;
    chk("a5_out_valid",   out_valid, 1);
    chk("a5_out_id",      out_id, 5);
    chk("a5_out_qos",     out_qos, 2);
    chk("a5_out_payload", out_payload, {16{8'hA5}});
    chk("a5_outstanding", outstanding, 1);
    tick();
    chk("a5_popped", out_valid, 0);

    // Re-offer id 5 while in flight: conflict, then complete and re-accept.
    offer(6'd5, 2'd1, 128'h55);
    #1;
    chk("c5_conflict", conflict_c, 1);
    tick();
    chk("c5_no_push",     out_valid, 0);
    chk("c5_outstanding", outstanding, 1);
    done_valid = 1'b1;
    done_id    = 6'd5;
    #1;
    chk("c5_conflict_preclear", conflict_c, 1);
    tick();
    done_valid = 1'b0;
    chk("c5_release",     release_c, 1);
    chk("c5_releaseid",   releaseid_c, 5);
    chk("c5_outstanding0", outstanding, 0);
    #1;
    chk("c5_conflict_gone", conflict_c, 0);
    tick();
    valid_c = 1'b0;
    chk("c5_reaccept_id",  out_id, 5);
    chk("c5_reaccept_cnt", outstanding, 1);
    chk("c5_release_drop", release_c, 0);
    done_valid = 1'b1;
    done_id    = 6'd5;
    tick();
    done_valid = 1'b0;
    chk("c5_drained", outstanding, 0);

    // Fill the FIFO with ids 0..3 while downstream stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(6'(i), 2'(i), 128'(i + 100));
      tick();
    end
    chk("fill_ready_low",  ready_c, 0);
    chk("fill_outstanding", outstanding, 4);
    offer(6'd4, 2'd0, 128'hDEAD);
    tick();
    valid_c = 1'b0;
    chk("fill_5th_held", outstanding, 4);
    chk("fill_head_id",  out_id, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid",   out_valid, 1);
      chk("drain_id",      out_id, 6'(i));
      chk("drain_payload", out_payload, 128'(i + 100));
      tick();
    end
    chk("drain_empty", out_valid, 0);

    // Accept id 7 while completing id 3 in the same cycle.
    offer(6'd7, 2'd3, 128'h77);
    done_valid = 1'b1;
    done_id    = 6'd3;
    tick();
    valid_c    = 1'b0;
    done_valid = 1'b0;
    chk("mix_outstanding", outstanding, 4);
    chk("mix_release",     release_c, 1);
    chk("mix_releaseid",   releaseid_c, 3);
    chk("mix_out_id",      out_id, 7);
    offer(6'd7, 2'd0, 128'h0);
    #1;
    chk("mix_busy7", conflict_c, 1);
    valid_c = 1'b0;
    tick();

    // Completion for an id never accepted.
    done_valid = 1'b1;
    done_id    = 6'd9;
    tick();
    done_valid = 1'b0;
    chk("sp_err",         err_spurious, 1);
    chk("sp_no_release",  release_c, 0);
    chk("sp_outstanding", outstanding, 4);
    tick();
    chk("sp_sticky", err_spurious, 1);

    // Leave 3 ids in flight (7, 10, 11) with 10 and 11 parked in the FIFO.
    for (int i = 0; i < 3; i++) begin
      done_valid = 1'b1;
      done_id    = 6'(i);
      tick();
    end
    done_valid = 1'b0;
    out_ready  = 1'b0;
    offer(6'd10, 2'd0, 128'hA);
    tick();
    offer(6'd11, 2'd1, 128'hB);
    tick();
    valid_c = 1'b0;
    chk("pre_rst_outstanding", outstanding, 3);
    chk("pre_rst_out_valid",   out_valid, 1);
    chk("pre_rst_out_id",      out_id, 10);

    // Asynchronous reset mid-operation.
    #2;
    rst_n = 1'b0;
    offer(6'd10, 2'd0, 128'hC);
    #1;
    chk("mr_out_valid",   out_valid, 0);
    chk("mr_outstanding", outstanding, 0);
    chk("mr_err",         err_spurious, 0);
    chk("mr_release",     release_c, 0);
    chk("mr_releaseid",   releaseid_c, 0);
    chk("mr_conflict",    conflict_c, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_ready", ready_c, 1);
    tick();
    valid_c = 1'b0;
    chk("mr_reuse_cnt", outstanding, 1);
    chk("mr_reuse_id",  out_id, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
